// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : router_pkg
// Purpose  : Shared types, port address constants and decode helpers for the
//            1x3 packet router synchroniser.
// Revision : 1.0 - initial release
// ============================================================================
package router_pkg;

  typedef logic [1:0] port_addr_t;

  localparam port_addr_t PORT0        = 2'b00;
  localparam port_addr_t PORT1        = 2'b01;
  localparam port_addr_t PORT2        = 2'b10;
  localparam port_addr_t PORT_INVALID = 2'b11;

  localparam int ROUTER_TIMEOUT = 30;

  // One-hot FIFO select; the invalid address selects nothing.
  function automatic logic [2:0] addr_onehot(input port_addr_t addr);
    case (addr)
      PORT0:        addr_onehot = 3'b001;
      PORT1:        addr_onehot = 3'b010;
      PORT2:        addr_onehot = 3'b100;
      PORT_INVALID: addr_onehot = 3'b000;
      default:      addr_onehot = 3'b000;
    endcase
  endfunction

endpackage : router_pkg
`default_nettype wire

// File: rtl/router_sync_if.sv
`default_nettype none
// ============================================================================
// Module   : router_sync_if
// Purpose  : Control/status bundle between the router FSM, the three output
//            FIFOs and the synchroniser block.
// Revision : 1.0 - initial release
// ============================================================================
interface router_sync_if;
  import router_pkg::*;

  logic       detect_add;
  port_addr_t data_in;
  logic       write_enb_reg;
  logic       full_0, full_1, full_2;
  logic       empty_0, empty_1, empty_2;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;

  modport master (
    output detect_add, data_in, write_enb_reg,
    output full_0, full_1, full_2, empty_0, empty_1, empty_2,
    output read_enb_0, read_enb_1, read_enb_2,
    input  write_enb, fifo_full, vld_out_0, vld_out_1, vld_out_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2
  );

  modport slave (
    input  detect_add, data_in, write_enb_reg,
    input  full_0, full_1, full_2, empty_0, empty_1, empty_2,
    input  read_enb_0, read_enb_1, read_enb_2,
    output write_enb, fifo_full, vld_out_0, vld_out_1, vld_out_2,
    output soft_reset_0, soft_reset_1, soft_reset_2
  );

endinterface : router_sync_if
`default_nettype wire

// File: rtl/router_sync_timer.sv
`default_nettype none
// ============================================================================
// Module   : router_sync_timer
// Purpose  : Per-port stall timer; pulses soft_reset for one cycle after
//            TIMEOUT consecutive edges with data valid but not read.
// Revision : 1.0 - initial release
// ============================================================================
module router_sync_timer #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  wire logic clock,
  input  wire logic resetn,
  input  wire logic vld,
  input  wire logic rd,
  output logic      soft_reset
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_soft_reset;
  logic             w_stalled;

  assign w_stalled = vld & ~rd;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt        <= '0;
      r_soft_reset <= 1'b0;
    end else if (!w_stalled) begin
      r_cnt        <= '0;
      r_soft_reset <= 1'b0;
    end else if (r_cnt == C_CNT_LAST) begin
      // Restart the window so a persisting stall re-flushes every TIMEOUT cycles.
      r_cnt        <= '0;
      r_soft_reset <= 1'b1;
    end else begin
      r_cnt        <= r_cnt + CNT_W'(1);
      r_soft_reset <= 1'b0;
    end
  end

  assign soft_reset = r_soft_reset;

endmodule : router_sync_timer
`default_nettype wire

// File: rtl/router_sync.sv
`default_nettype none
// ============================================================================
// Module   : router_sync
// Purpose  : 1x3 router synchroniser: latches the destination address,
//            steers FIFO write enables, muxes the addressed full flag and
//            drives per-port valid and soft-reset flush pulses.
//            Option macro: ROUTER_SYNC_ADDR_BYPASS_EN (zero-cycle steering).
// Revision : 1.0 - initial release
// ============================================================================
module router_sync
  import router_pkg::*;
#(
  parameter int TIMEOUT = ROUTER_TIMEOUT,
  parameter int CNT_W   = 5
) (
  input  wire logic    clock,
  input  wire logic    resetn,
  router_sync_if.slave bus
);

  port_addr_t r_addr;
  port_addr_t w_sel;
  logic [2:0] w_vld;
  logic [2:0] w_rd;
  logic [2:0] w_soft_reset;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_addr <= PORT0;
    end else if (bus.detect_add) begin
      r_addr <= bus.data_in;
    end
  end

`ifdef ROUTER_SYNC_ADDR_BYPASS_EN
  assign w_sel = bus.detect_add ? bus.data_in : r_addr;
`else
  assign w_sel = r_addr;
`endif

  assign bus.write_enb = bus.write_enb_reg ? addr_onehot(w_sel) : 3'b000;

  always_comb begin
    bus.fifo_full = 1'b0;
    case (w_sel)
      PORT0:   bus.fifo_full = bus.full_0;
      PORT1:   bus.fifo_full = bus.full_1;
      PORT2:   bus.fifo_full = bus.full_2;
      default: bus.fifo_full = 1'b0;
    endcase
  end

  assign w_vld = {~bus.empty_2, ~bus.empty_1, ~bus.empty_0};
  assign w_rd  = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};

  for (genvar i = 0; i < 3; i++) begin : g_timer
    router_sync_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_timer (
      .clock      (clock),
      .resetn     (resetn),
      .vld        (w_vld[i]),
      .rd         (w_rd[i]),
      .soft_reset (w_soft_reset[i])
    );
  end

  assign bus.vld_out_0    = w_vld[0];
  assign bus.vld_out_1    = w_vld[1];
  assign bus.vld_out_2    = w_vld[2];
  assign bus.soft_reset_0 = w_soft_reset[0];
  assign bus.soft_reset_1 = w_soft_reset[1];
  assign bus.soft_reset_2 = w_soft_reset[2];

endmodule : router_sync
`default_nettype wire

// File: tb/tb_router_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_sync
// Purpose  : Self-checking bench for router_sync: decode vector table plus
//            scoreboarded stall/soft-reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_sync;
  import router_pkg::*;

  logic clock;
  logic resetn;
  int   n_cmp = 0;
  int   n_err = 0;

  router_sync_if bus ();

  router_sync #(
    .TIMEOUT (30),
    .CNT_W   (5)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    port_addr_t addr;
    logic       wreg;
    logic [2:0] full;
    logic [2:0] exp_we;
    logic       exp_ff;
  } vec_t;

  typedef struct {
    string      tag;
    logic [2:0] srst;
    logic [2:0] vld;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ports(input logic [2:0] empty, input logic [2:0] rd);
    {bus.empty_2, bus.empty_1, bus.empty_0}          = empty;
    {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0} = rd;
  endtask

  // Push the expectation for the coming edge, then pop it once the DUT has updated.
  task automatic step(input string tag, input logic [2:0] exp_srst);
    exp_t e;
    e.tag  = tag;
    e.srst = exp_srst;
    e.vld  = ~{bus.empty_2, bus.empty_1, bus.empty_0};
    sb.push_back(e);
    tick();
    e = sb.pop_front();
    chk({e.tag, "_srst"}, {5'd0, bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0}, {5'd0, e.srst});
    chk({e.tag, "_vld"},  {5'd0, bus.vld_out_2, bus.vld_out_1, bus.vld_out_0},          {5'd0, e.vld});
  endtask

  task automatic latch_addr(input port_addr_t a);
    bus.detect_add    = 1'b1;
    bus.data_in       = a;
    bus.write_enb_reg = 1'b0;
    tick();
    bus.detect_add    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    vecs[0] = '{2'b01, 1'b1, 3'b010, 3'b010, 1'b1};
    vecs[1] = '{2'b01, 1'b1, 3'b001, 3'b010, 1'b0};
    vecs[2] = '{2'b00, 1'b1, 3'b001, 3'b001, 1'b1};
    vecs[3] = '{2'b00, 1'b0, 3'b110, 3'b000, 1'b0};
    vecs[4] = '{2'b10, 1'b1, 3'b100, 3'b100, 1'b1};
    vecs[5] = '{2'b10, 1'b1, 3'b011, 3'b100, 1'b0};
    vecs[6] = '{2'b11, 1'b1, 3'b111, 3'b000, 1'b0};
    vecs[7] = '{2'b11, 1'b0, 3'b111, 3'b000, 1'b0};
    vecs[8] = '{2'b01, 1'b0, 3'b010, 3'b000, 1'b1};

    // Reset state: combinational outputs decode address 00.
    resetn            = 1'b0;
    bus.detect_add    = 1'b0;
    bus.data_in       = 2'b10;
    bus.write_enb_reg = 1'b1;
    {bus.full_2, bus.full_1, bus.full_0} = 3'b001;
    set_ports(3'b111, 3'b000);
    #2;
    chk("rst_we",   {5'd0, bus.write_enb}, 8'h01);
    chk("rst_ff",   {7'd0, bus.fifo_full}, 8'h01);
    chk("rst_srst", {5'd0, bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0}, 8'h00);
    #10 resetn = 1'b1;
    tick();

    // Address decode table.
    foreach (vecs[i]) begin
      latch_addr(vecs[i].addr);
      bus.write_enb_reg = vecs[i].wreg;
      {bus.full_2, bus.full_1, bus.full_0} = vecs[i].full;
      #1;
      chk($sformatf("vec%0d_we", i), {5'd0, bus.write_enb}, {5'd0, vecs[i].exp_we});
      chk($sformatf("vec%0d_ff", i), {7'd0, bus.fifo_full}, {7'd0, vecs[i].exp_ff});
    end

    // Capture cycle with write request: old address unless bypass is built in.
    latch_addr(PORT1);
    {bus.full_2, bus.full_1, bus.full_0} = 3'b100;
    bus.detect_add    = 1'b1;
    bus.data_in       = PORT2;
    bus.write_enb_reg = 1'b1;
    #1;
`ifdef ROUTER_SYNC_ADDR_BYPASS_EN
    chk("cap_we", {5'd0, bus.write_enb}, 8'h04);
    chk("cap_ff", {7'd0, bus.fifo_full}, 8'h01);
`else
    chk("cap_we", {5'd0, bus.write_enb}, 8'h02);
    chk("cap_ff", {7'd0, bus.fifo_full}, 8'h00);
`endif
    tick();
    bus.detect_add = 1'b0;
    #1;
    chk("post_cap_we", {5'd0, bus.write_enb}, 8'h04);
    bus.write_enb_reg = 1'b0;

    // Port 0 stalled 60 edges: pulses after edges 30 and 60 only.
    set_ports(3'b110, 3'b000);
    for (int k = 1; k <= 60; k++)
      step("stall60", (k == 30 || k == 60) ? 3'b001 : 3'b000);
    set_ports(3'b111, 3'b000);
    step("idle", 3'b000);

    // 29 stalled, one read, 29 stalled: no pulse; the next stalled edge completes a window.
    set_ports(3'b110, 3'b000);
    for (int k = 1; k <= 29; k++) step("pre_rd", 3'b000);
    set_ports(3'b110, 3'b001);
    step("rd", 3'b000);
    set_ports(3'b110, 3'b000);
    for (int k = 1; k <= 29; k++) step("post_rd", 3'b000);
    step("post_rd_30", 3'b001);
    set_ports(3'b111, 3'b000);
    step("idle", 3'b000);

    // empty_2 toggling and then held high: vld follows instantly, never flushes.
    for (int k = 0; k < 8; k++) begin
      set_ports({k[0], 2'b11}, 3'b000);
      #1;
      chk("vld2_comb", {7'd0, bus.vld_out_2}, {7'd0, ~k[0]});
      step("toggle2", 3'b000);
    end
    set_ports(3'b111, 3'b000);
    for (int k = 1; k <= 40; k++) step("empty2", 3'b000);

    // Async reset at count 20 clears timers and address.
    latch_addr(PORT2);
    set_ports(3'b100, 3'b000);
    for (int k = 1; k <= 20; k++) step("cnt20", 3'b000);
    #2 resetn = 1'b0;
    bus.write_enb_reg = 1'b1;
    #1;
    chk("arst_srst", {5'd0, bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0}, 8'h00);
    chk("arst_we",   {5'd0, bus.write_enb}, 8'h01);
    @(negedge clock) resetn = 1'b1;
    bus.write_enb_reg = 1'b0;
    for (int k = 1; k <= 30; k++) step("after_rst", (k == 30) ? 3'b011 : 3'b000);

    // Reset while a pulse is high drops it immediately.
    #1 resetn = 1'b0;
    #1;
    chk("arst_pulse", {5'd0, bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0}, 8'h00);
    @(negedge clock) resetn = 1'b1;
    set_ports(3'b111, 3'b000);
    step("final", 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_router_sync
`default_nettype wire
